// File: rtl/miss_handling_queue.sv
`default_nettype none
// ============================================================================
// Module   : miss_handling_queue
// Brief    : In-order miss queue merging same-line misses, one bus read per
//            entry, one-cycle merged cacheline fill back to the LSU/dcache.
// Revision : 1.0
// ============================================================================
module miss_handling_queue #(
    parameter int MHQ_DEPTH  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    localparam int TW = (MHQ_DEPTH > 1) ? $clog2(MHQ_DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    i_enq_en,
    input  logic                    i_enq_we,
    input  logic [ADDR_WIDTH-1:0]   i_enq_addr,
    input  logic [DATA_WIDTH-1:0]   i_enq_data,
    input  logic [DATA_WIDTH/8-1:0] i_enq_byte_select,
    output logic [TW-1:0]           o_enq_tag,
    output logic                    o_full,
    output logic                    o_bus_req_en,
    output logic [ADDR_WIDTH-1:0]   o_bus_req_addr,
    input  logic                    i_bus_ack,
    input  logic                    i_bus_data_valid,
    input  logic [LINE_WIDTH-1:0]   i_bus_data,
    output logic                    o_fill,
    output logic [TW-1:0]           o_fill_tag,
    output logic [ADDR_WIDTH-1:0]   o_fill_addr,
    output logic [LINE_WIDTH-1:0]   o_fill_data,
    output logic                    o_fill_dirty
);

    localparam int CW   = $clog2(MHQ_DEPTH + 1);
    localparam int NB   = LINE_WIDTH / 8;
    localparam int WB   = DATA_WIDTH / 8;
    localparam int OFS  = $clog2(NB);
    localparam int WOFS = $clog2(WB);
    localparam int LAW  = ADDR_WIDTH - OFS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FILL = 2'd3
    } state_t;

    logic [MHQ_DEPTH-1:0]  valid_q;
    logic [MHQ_DEPTH-1:0]  dirty_q;
    logic [LAW-1:0]        laddr_q [MHQ_DEPTH];
    logic [NB-1:0]         mask_q  [MHQ_DEPTH];
    logic [LINE_WIDTH-1:0] sbuf_q  [MHQ_DEPTH];
    logic [LINE_WIDTH-1:0] mem_q   [MHQ_DEPTH];
    logic [TW-1:0]         head_q, tail_q;
    logic [CW-1:0]         count_q, count_d;
    state_t                state_q;

    logic [LAW-1:0]        w_enq_laddr;
    logic [OFS-WOFS-1:0]   w_word_idx;
    logic [LINE_WIDTH-1:0] w_st_line;
    logic [NB-1:0]         w_st_mask;
    logic                  w_hit;
    logic [TW-1:0]         w_hit_idx;
    logic                  w_full, w_alloc, w_merge, w_deq;
    logic [TW-1:0]         w_head_nxt;
    logic                  w_unused_addr_lsbs;

    function automatic logic [TW-1:0] wrap_inc(input logic [TW-1:0] p);
        return (p == TW'(MHQ_DEPTH - 1)) ? '0 : p + TW'(1);
    endfunction

    assign w_enq_laddr        = i_enq_addr[ADDR_WIDTH-1:OFS];
    assign w_word_idx         = i_enq_addr[OFS-1:WOFS];
    assign w_unused_addr_lsbs = ^i_enq_addr[WOFS-1:0];
    assign w_st_line          = LINE_WIDTH'(i_enq_data) << (int'(w_word_idx) * DATA_WIDTH);
    assign w_st_mask          = i_enq_we ? (NB'(i_enq_byte_select) << (int'(w_word_idx) * WB)) : '0;

    // The head is being retired during FILL, so it must not absorb new merges.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < MHQ_DEPTH; i++) begin
            if (!w_hit && valid_q[i] && (laddr_q[i] == w_enq_laddr) &&
                !((state_q == S_FILL) && (head_q == TW'(i)))) begin
                w_hit     = 1'b1;
                w_hit_idx = TW'(i);
            end
        end
    end

    assign w_full     = (count_q == CW'(MHQ_DEPTH));
    assign w_alloc    = i_enq_en && !w_hit && !w_full;
    assign w_merge    = i_enq_en && w_hit && i_enq_we;
    assign w_deq      = (state_q == S_FILL);
    assign w_head_nxt = wrap_inc(head_q);
    assign count_d    = count_q + CW'(w_alloc) - CW'(w_deq);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_q <= '0;
            dirty_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= S_IDLE;
            for (int i = 0; i < MHQ_DEPTH; i++) begin
                laddr_q[i] <= '0;
                mask_q[i]  <= '0;
            end
        end else begin
            count_q <= count_d;
            if (w_deq) begin
                valid_q[head_q] <= 1'b0;
            end
            if (w_alloc) begin
                valid_q[tail_q] <= 1'b1;
                laddr_q[tail_q] <= w_enq_laddr;
                mask_q[tail_q]  <= w_st_mask;
                dirty_q[tail_q] <= i_enq_we;
                tail_q          <= wrap_inc(tail_q);
            end
            if (w_merge) begin
                mask_q[w_hit_idx]  <= mask_q[w_hit_idx] | w_st_mask;
                dirty_q[w_hit_idx] <= 1'b1;
            end
            case (state_q)
                S_IDLE: if (valid_q[head_q]) state_q <= S_REQ;
                S_REQ:  if (i_bus_ack) state_q <= S_WAIT;
                S_WAIT: if (i_bus_data_valid) state_q <= S_FILL;
                S_FILL: begin
                    head_q  <= w_head_nxt;
                    state_q <= valid_q[w_head_nxt] ? S_REQ : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Line payloads need no reset: the byte mask decides what is meaningful.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MHQ_DEPTH; i++) begin
            if ((w_alloc && (tail_q == TW'(i))) || (w_merge && (w_hit_idx == TW'(i)))) begin
                for (int b = 0; b < NB; b++) begin
                    if (w_st_mask[b]) sbuf_q[i][8*b +: 8] <= w_st_line[8*b +: 8];
                end
            end
        end
        if ((state_q == S_WAIT) && i_bus_data_valid) begin
            mem_q[head_q] <= i_bus_data;
        end
    end

    assign o_enq_tag      = w_hit ? w_hit_idx : tail_q;
    assign o_full         = w_full;
    assign o_bus_req_en   = (state_q == S_REQ);
    assign o_bus_req_addr = (state_q == S_REQ) ? {laddr_q[head_q], {OFS{1'b0}}} : '0;
    assign o_fill         = (state_q == S_FILL);
    assign o_fill_tag     = (state_q == S_FILL) ? head_q : '0;
    assign o_fill_addr    = (state_q == S_FILL) ? {laddr_q[head_q], {OFS{1'b0}}} : '0;
    assign o_fill_dirty   = (state_q == S_FILL) && dirty_q[head_q];

    always_comb begin
        o_fill_data = '0;
        if (state_q == S_FILL) begin
            for (int b = 0; b < NB; b++) begin
                o_fill_data[8*b +: 8] = mask_q[head_q][b] ? sbuf_q[head_q][8*b +: 8]
                                                          : mem_q[head_q][8*b +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_miss_handling_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_miss_handling_queue
// Brief    : Self-checking bench: vector table, directed corner sequences and
//            randomized traffic against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_miss_handling_queue;

    logic         clk;
    logic         n_rst;
    logic         i_enq_en, i_enq_we;
    logic [31:0]  i_enq_addr, i_enq_data;
    logic [3:0]   i_enq_byte_select;
    logic [1:0]   o_enq_tag;
    logic         o_full, o_bus_req_en;
    logic [31:0]  o_bus_req_addr;
    logic         i_bus_ack, i_bus_data_valid;
    logic [127:0] i_bus_data;
    logic         o_fill;
    logic [1:0]   o_fill_tag;
    logic [31:0]  o_fill_addr;
    logic [127:0] o_fill_data;
    logic         o_fill_dirty;

    miss_handling_queue dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .i_enq_en          (i_enq_en),
        .i_enq_we          (i_enq_we),
        .i_enq_addr        (i_enq_addr),
        .i_enq_data        (i_enq_data),
        .i_enq_byte_select (i_enq_byte_select),
        .o_enq_tag         (o_enq_tag),
        .o_full            (o_full),
        .o_bus_req_en      (o_bus_req_en),
        .o_bus_req_addr    (o_bus_req_addr),
        .i_bus_ack         (i_bus_ack),
        .i_bus_data_valid  (i_bus_data_valid),
        .i_bus_data        (i_bus_data),
        .o_fill            (o_fill),
        .o_fill_tag        (o_fill_tag),
        .o_fill_addr       (o_fill_addr),
        .o_fill_data       (o_fill_data),
        .o_fill_dirty      (o_fill_dirty)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        en;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  bsel;
        logic [1:0]  etag;
        logic        efull;
    } vec_t;

    typedef struct {
        logic [27:0]  la;
        logic [127:0] sb;
        logic [15:0]  mk;
        logic         dirty;
        int           tag;
    } ment_t;

    vec_t  vt[8];
    ment_t mq[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [127:0] memline(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a, a + 32'h1111_1111, a[15:0], a[31:16]};
    endfunction

    function automatic logic [127:0] put_word(input logic [127:0] l, input int w,
                                              input logic [31:0] d, input logic [3:0] bs);
        logic [127:0] r;
        r = l;
        for (int b = 0; b < 4; b++) if (bs[b]) r[32*w + 8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [127:0] overlay(input logic [127:0] mem, input logic [127:0] sb,
                                             input logic [15:0] mk);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[8*b +: 8] = mk[b] ? sb[8*b +: 8] : mem[8*b +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        i_enq_en = 0; i_enq_we = 0; i_enq_addr = 0; i_enq_data = 0; i_enq_byte_select = 0;
        i_bus_ack = 0; i_bus_data_valid = 0; i_bus_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        n_rst = 0;
        repeat (2) @(posedge clk);
        #3 n_rst = 1;
    endtask

    task automatic enq(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] bs, input logic [1:0] etag, input string nm);
        @(posedge clk); #1;
        i_enq_en = 1; i_enq_we = we; i_enq_addr = a; i_enq_data = d; i_enq_byte_select = bs;
        #2 chk(nm, 128'(o_enq_tag), 128'(etag));
    endtask

    // Serves the current head with ack/data as soon as asked; optional store merge on the data cycle.
    task automatic serve(input logic [1:0] etag, input logic [31:0] eaddr, input logic [127:0] bline,
                         input logic [127:0] edata, input logic edirty, input bit mrg,
                         input logic [31:0] maddr, input logic [31:0] mdata, input logic [3:0] mbs,
                         output int ncyc);
        int  ph;
        bit  done;
        ph = 0; done = 0; ncyc = 0;
        while (!done && ncyc < 40) begin
            @(posedge clk); #1;
            ncyc++;
            idle_inputs();
            if (o_fill) begin
                chk("fill tag",   128'(o_fill_tag),   128'(etag));
                chk("fill addr",  128'(o_fill_addr),  128'(eaddr));
                chk("fill data",  o_fill_data,        edata);
                chk("fill dirty", 128'(o_fill_dirty), 128'(edirty));
                done = 1;
            end else if (ph == 0 && o_bus_req_en) begin
                chk("bus req addr", 128'(o_bus_req_addr), 128'(eaddr));
                i_bus_ack = 1;
                ph = 1;
            end else if (ph == 1) begin
                i_bus_data_valid = 1;
                i_bus_data = bline;
                ph = 2;
                if (mrg) begin
                    i_enq_en = 1; i_enq_we = 1; i_enq_addr = maddr;
                    i_enq_data = mdata; i_enq_byte_select = mbs;
                    #2 chk("merge on data cycle tag", 128'(o_enq_tag), 128'(etag));
                end
            end
        end
        if (!done) fail("serve timeout waiting for fill");
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        int           ncyc;
        int           sz0, j, bph, nfills;
        logic [31:0]  ackaddr, a;
        logic [127:0] e0, e2;
        ment_t        e;

        clk = 0;
        n_rst = 0;
        idle_inputs();

        // Reset state
        do_reset();
        #1;
        chk("rst full",       128'(o_full),         0);
        chk("rst bus_req_en", 128'(o_bus_req_en),   0);
        chk("rst bus_addr",   128'(o_bus_req_addr), 0);
        chk("rst fill",       128'(o_fill),         0);
        chk("rst fill_tag",   128'(o_fill_tag),     0);
        chk("rst fill_addr",  128'(o_fill_addr),    0);
        chk("rst fill_data",  o_fill_data,          0);
        chk("rst fill_dirty", 128'(o_fill_dirty),   0);
        chk("rst enq_tag",    128'(o_enq_tag),      0);

        // Single load miss, minimum latency
        enq(0, 32'h1004, 0, 0, 0, "t1 enq tag");
        serve(0, 32'h1000, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA,
              128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 0, 0, 0, 0, 0, ncyc);
        chk("t1 alloc-to-fill latency", 128'(ncyc - 1), 3);
        chk("t1 full after", 128'(o_full), 0);

        // Store then load to the same line before data returns
        do_reset();
        enq(1, 32'h2008, 32'h11223344, 4'b0011, 0, "t2 store tag");
        enq(0, 32'h200C, 0, 0, 0, "t2 load merge tag");
        serve(0, 32'h2000, memline(32'h2000),
              put_word(memline(32'h2000), 2, 32'h11223344, 4'b0011), 1, 0, 0, 0, 0, ncyc);
        #2 chk("t2 single bus req", 128'(o_bus_req_en), 0);

        // Store merge on the data-return cycle
        do_reset();
        enq(0, 32'h3000, 0, 0, 0, "t3 enq tag");
        serve(0, 32'h3000, memline(32'h3000),
              put_word(memline(32'h3000), 1, 32'hCAFEF00D, 4'hF), 1,
              1, 32'h3004, 32'hCAFEF00D, 4'hF, ncyc);

        // Fill to full, drop, merge while full (bus held off)
        do_reset();
        vt[0] = '{1'b1, 1'b0, 32'h1000_0040, 32'h0,         4'h0,    2'd0, 1'b0};
        vt[1] = '{1'b1, 1'b0, 32'h1000_0080, 32'h0,         4'h0,    2'd1, 1'b0};
        vt[2] = '{1'b1, 1'b1, 32'h1000_00C4, 32'hAABBCCDD,  4'hF,    2'd2, 1'b0};
        vt[3] = '{1'b1, 1'b0, 32'h1000_0100, 32'h0,         4'h0,    2'd3, 1'b0};
        vt[4] = '{1'b0, 1'b0, 32'hFFFF_0000, 32'h0,         4'h0,    2'd0, 1'b1};
        vt[5] = '{1'b1, 1'b0, 32'h2000_0000, 32'h0,         4'h0,    2'd0, 1'b1};
        vt[6] = '{1'b1, 1'b1, 32'h1000_00C8, 32'h01020304,  4'b0101, 2'd2, 1'b1};
        vt[7] = '{1'b0, 1'b0, 32'hFFFF_0000, 32'h0,         4'h0,    2'd0, 1'b1};
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            i_enq_en = vt[k].en; i_enq_we = vt[k].we; i_enq_addr = vt[k].addr;
            i_enq_data = vt[k].data; i_enq_byte_select = vt[k].bsel;
            #2;
            chk($sformatf("vec%0d tag", k),  128'(o_enq_tag), 128'(vt[k].etag));
            chk($sformatf("vec%0d full", k), 128'(o_full),    128'(vt[k].efull));
        end
        // Bus never acks: request must stay put
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            idle_inputs();
            #2;
            chk("stall req_en",   128'(o_bus_req_en),   1);
            chk("stall req_addr", 128'(o_bus_req_addr), 128'(32'h1000_0040));
            chk("stall no fill",  128'(o_fill),         0);
        end
        e2 = put_word(put_word(memline(32'h1000_00C0), 1, 32'hAABBCCDD, 4'hF),
                      2, 32'h01020304, 4'b0101);
        serve(0, 32'h1000_0040, memline(32'h1000_0040), memline(32'h1000_0040), 0, 0, 0, 0, 0, ncyc);
        serve(1, 32'h1000_0080, memline(32'h1000_0080), memline(32'h1000_0080), 0, 0, 0, 0, 0, ncyc);
        serve(2, 32'h1000_00C0, memline(32'h1000_00C0), e2,                     1, 0, 0, 0, 0, ncyc);
        serve(3, 32'h1000_0100, memline(32'h1000_0100), memline(32'h1000_0100), 0, 0, 0, 0, 0, ncyc);
        chk("t4 full cleared", 128'(o_full), 0);
        enq(0, 32'h6000, 0, 0, 0, "t4 tail wrap tag");
        serve(0, 32'h6000, memline(32'h6000), memline(32'h6000), 0, 0, 0, 0, 0, ncyc);

        // Reset while waiting for data
        do_reset();
        enq(0, 32'h4000, 0, 0, 0, "t6 enq tag");
        j = 0;
        for (int k = 0; k < 10 && j == 0; k++) begin
            @(posedge clk); #1;
            idle_inputs();
            if (o_bus_req_en) begin i_bus_ack = 1; j = 1; end
        end
        if (j == 0) fail("t6 no bus request");
        @(posedge clk); #1;
        idle_inputs();
        #2 n_rst = 0;
        #1;
        chk("t6 rst req_en",    128'(o_bus_req_en),   0);
        chk("t6 rst req_addr",  128'(o_bus_req_addr), 0);
        chk("t6 rst fill",      128'(o_fill),         0);
        chk("t6 rst fill_data", o_fill_data,          0);
        chk("t6 rst full",      128'(o_full),         0);
        @(posedge clk); #3 n_rst = 1;
        enq(0, 32'h5040, 0, 0, 0, "t6 post-reset tag");
        serve(0, 32'h5040, memline(32'h5040), memline(32'h5040), 0, 0, 0, 0, 0, ncyc);

        // Randomized traffic against a queue model
        do_reset();
        mq.delete();
        j = 0; bph = 0; nfills = 0; ackaddr = 0;
        sz0 = 0;
        begin : g_rand
            int m_tail;
            m_tail = 0;
            for (int cyc = 0; cyc < 1500; cyc++) begin
                if (cyc >= 600 && mq.size() == 0 && bph == 0) break;
                @(posedge clk); #1;
                idle_inputs();
                if (cyc < 600 && $urandom_range(0, 2) != 0) begin
                    i_enq_en = 1;
                    i_enq_we = 1'($urandom_range(0, 1));
                    a = 32'h8000_0000 | (32'($urandom_range(0, 5)) << 4) | (32'($urandom_range(0, 3)) << 2);
                    if (!i_enq_we) a = a | 32'($urandom_range(0, 3));
                    i_enq_addr = a;
                    i_enq_data = $urandom;
                    i_enq_byte_select = 4'($urandom_range(0, 15));
                end
                if (o_bus_req_en && bph == 0 && $urandom_range(0, 2) == 0) begin
                    i_bus_ack = 1; bph = 1; ackaddr = o_bus_req_addr;
                end else if (bph == 1 && $urandom_range(0, 2) == 0) begin
                    i_bus_data_valid = 1; i_bus_data = memline(ackaddr); bph = 0;
                end else if (bph == 0 && !o_bus_req_en && $urandom_range(0, 7) == 0) begin
                    i_bus_ack = 1;
                end else if (bph == 0 && $urandom_range(0, 7) == 0) begin
                    i_bus_data_valid = 1; i_bus_data = {4{32'hDEAD_BEEF}};
                end
                #2;
                sz0 = mq.size();
                if (o_fill) begin
                    if (sz0 == 0) fail("rand unexpected fill");
                    else begin
                        e = mq.pop_front();
                        nfills++;
                        chk("rand fill tag",   128'(o_fill_tag),   128'(e.tag));
                        chk("rand fill addr",  128'(o_fill_addr),  128'({e.la, 4'h0}));
                        chk("rand fill data",  o_fill_data,        overlay(memline({e.la, 4'h0}), e.sb, e.mk));
                        chk("rand fill dirty", 128'(o_fill_dirty), 128'(e.dirty));
                    end
                end
                chk("rand full", 128'(o_full), 128'(sz0 == 4));
                if (o_bus_req_en) begin
                    if (mq.size() == 0) fail("rand unexpected bus req");
                    else chk("rand bus addr", 128'(o_bus_req_addr), 128'({mq[0].la, 4'h0}));
                end
                if (i_enq_en) begin
                    j = -1;
                    for (int k = 0; k < mq.size(); k++)
                        if (j < 0 && mq[k].la == i_enq_addr[31:4]) j = k;
                    chk("rand enq tag", 128'(o_enq_tag), 128'((j >= 0) ? mq[j].tag : m_tail));
                    if (j >= 0) begin
                        if (i_enq_we) begin
                            e = mq[j];
                            e.sb = put_word(e.sb, int'(i_enq_addr[3:2]), i_enq_data, i_enq_byte_select);
                            e.mk = e.mk | (16'(i_enq_byte_select) << (4 * int'(i_enq_addr[3:2])));
                            e.dirty = 1;
                            mq[j] = e;
                        end
                    end else if (sz0 < 4) begin
                        e.la = i_enq_addr[31:4];
                        e.sb = '0;
                        e.mk = '0;
                        e.dirty = i_enq_we;
                        e.tag = m_tail;
                        if (i_enq_we) begin
                            e.sb = put_word('0, int'(i_enq_addr[3:2]), i_enq_data, i_enq_byte_select);
                            e.mk = 16'(i_enq_byte_select) << (4 * int'(i_enq_addr[3:2]));
                        end
                        mq.push_back(e);
                        m_tail = (m_tail + 1) % 4;
                    end
                end
            end
        end
        idle_inputs();
        chk("rand drain left entries", 128'(mq.size()), 0);
        if (nfills < 20) fail($sformatf("rand too few fills got %0d need >=20", nfills));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
